// File: rtl/kernel_nios2_qsys_0_oci_dct_packer.sv
// DCT code packer: shifts 2-bit trace codes into a 30-bit buffer and hands full or
// flushed words to the trace FIFO through a one-entry holding register.
module kernel_nios2_qsys_0_oci_dct_packer #(
    parameter int WORD_CODES = 15,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  trc_on_i,
    input  logic                  dct_valid_i,
    input  logic [1:0]            dct_code_i,
    input  logic                  flush_i,
    input  logic                  fifo_full_i,
    output logic                  fifo_wrreq_o,
    output logic [35:0]           fifo_wrdata_o,
    output logic [29:0]           dct_buffer_o,
    output logic [3:0]            dct_count_o,
    output logic [DROP_CNT_W-1:0] dropped_count_o,
    output logic                  overflow_o
);

    localparam logic [3:0] WORD_CNT = 4'(WORD_CODES);

    logic [29:0]           buffer_q,   buffer_d;
    logic [3:0]            count_q,    count_d;
    logic                  wrreq_q,    wrreq_d;
    logic [35:0]           wrdata_q,   wrdata_d;
    logic [DROP_CNT_W-1:0] dropped_q,  dropped_d;
    logic                  overflow_q, overflow_d;
    logic                  ovf_pend_q, ovf_pend_d;

    logic        cnt_full_s;
    logic        hold_free_s;
    logic        emit_s;
    logic        write_s;
    logic        code_in_s;
    logic        accept_s;
    logic        drop_s;
    logic [29:0] base_buf_s;
    logic [3:0]  base_cnt_s;

    assign cnt_full_s  = (count_q == WORD_CNT);
    assign hold_free_s = ~wrreq_q | ~fifo_full_i;
    assign write_s     = wrreq_q & ~fifo_full_i;
    assign emit_s      = hold_free_s & (cnt_full_s | (flush_i & (count_q != 4'd0)));
    assign code_in_s   = trc_on_i & dct_valid_i;
    // An emit empties the buffer first, so a full buffer only drops when it cannot emit.
    assign accept_s    = code_in_s & (~cnt_full_s | emit_s);
    assign drop_s      = code_in_s & cnt_full_s & ~emit_s;

    assign base_buf_s  = emit_s ? 30'd0 : buffer_q;
    assign base_cnt_s  = emit_s ? 4'd0  : count_q;

    // Next-state for packing buffer, holding register and drop bookkeeping.
    always_comb begin
        buffer_d   = base_buf_s;
        count_d    = base_cnt_s;
        wrreq_d    = wrreq_q;
        wrdata_d   = wrdata_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        ovf_pend_d = ovf_pend_q;

        if (accept_s) begin
            buffer_d = {dct_code_i, base_buf_s[29:2]};
            count_d  = base_cnt_s + 4'd1;
        end else begin
            buffer_d = base_buf_s;
            count_d  = base_cnt_s;
        end

        if (emit_s) begin
            wrdata_d   = {ovf_pend_q, 1'b0, count_q, buffer_q};
            wrreq_d    = 1'b1;
            ovf_pend_d = 1'b0;
        end else if (write_s) begin
            wrreq_d = 1'b0;
        end else begin
            wrreq_d = wrreq_q;
        end

        if (drop_s) begin
            overflow_d = 1'b1;
            ovf_pend_d = 1'b1;
            if (dropped_q != {DROP_CNT_W{1'b1}}) begin
                dropped_d = dropped_q + DROP_CNT_W'(1);
            end else begin
                dropped_d = dropped_q;
            end
        end else begin
            dropped_d = dropped_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buffer_q   <= 30'd0;
            count_q    <= 4'd0;
            wrreq_q    <= 1'b0;
            wrdata_q   <= 36'd0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            buffer_q   <= buffer_d;
            count_q    <= count_d;
            wrreq_q    <= wrreq_d;
            wrdata_q   <= wrdata_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    assign fifo_wrreq_o    = wrreq_q;
    assign fifo_wrdata_o   = wrdata_q;
    assign dct_buffer_o    = buffer_q;
    assign dct_count_o     = count_q;
    assign dropped_count_o = dropped_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_kernel_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: a list-of-codes reference model predicts
// emitted words; a negedge monitor checks every FIFO write against the queue.
module tb_kernel_nios2_qsys_0_oci_dct_packer;

    localparam int WC = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          trc_on = 1'b0;
    logic          dct_valid = 1'b0;
    logic [1:0]    dct_code = 2'd0;
    logic          flush = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_wrreq;
    logic [35:0]   fifo_wrdata;
    logic [29:0]   dct_buffer;
    logic [3:0]    dct_count;
    logic [DW-1:0] dropped_count;
    logic          overflow;

    kernel_nios2_qsys_0_oci_dct_packer #(.WORD_CODES(WC), .DROP_CNT_W(DW)) dut (
        .clk_i(clk), .reset_i(reset), .trc_on_i(trc_on), .dct_valid_i(dct_valid),
        .dct_code_i(dct_code), .flush_i(flush), .fifo_full_i(fifo_full),
        .fifo_wrreq_o(fifo_wrreq), .fifo_wrdata_o(fifo_wrdata),
        .dct_buffer_o(dct_buffer), .dct_count_o(dct_count),
        .dropped_count_o(dropped_count), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: codes held in the buffer, hold occupancy, drop bookkeeping.
    int unsigned  m_codes[$];
    bit           m_hold = 1'b0;
    bit           m_pend = 1'b0;
    bit           m_ovf  = 1'b0;
    int           m_drops = 0;
    logic [35:0]  exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Newest code at [29:28], older codes at successively lower pairs, rest zero.
    function automatic logic [29:0] pack();
        logic [29:0] b;
        int n;
        b = '0;
        n = m_codes.size();
        for (int j = 0; j < n; j++) b[29-2*j -: 2] = 2'(m_codes[n-1-j]);
        return b;
    endfunction

    task automatic step(input bit v, input logic [1:0] c, input bit fl, input bit full, input bit trc);
        bit free, emit;
        int n;
        trc_on = trc; dct_valid = v; dct_code = c; flush = fl; fifo_full = full;
        n    = m_codes.size();
        free = !m_hold || !full;
        emit = free && (n == WC || (fl && n != 0));
        if (emit) begin
            exp_q.push_back({m_pend, 1'b0, 4'(n), pack()});
            m_codes.delete();
            m_pend = 1'b0;
            m_hold = 1'b1;
        end else if (m_hold && !full) begin
            m_hold = 1'b0;
        end
        if (trc && v) begin
            if (m_codes.size() < WC) m_codes.push_back(int'(c));
            else begin
                if (m_drops < 255) m_drops++;
                m_ovf  = 1'b1;
                m_pend = 1'b1;
            end
        end
        @(posedge clk); #2;
        chk("dct_count",     dct_count,     m_codes.size());
        chk("dct_buffer",    dct_buffer,    pack());
        chk("fifo_wrreq",    fifo_wrreq,    m_hold);
        chk("dropped_count", dropped_count, m_drops);
        chk("overflow",      overflow,      m_ovf);
    endtask

    task automatic idle(input bit full);
        step(1'b0, 2'd0, 1'b0, full, 1'b1);
    endtask

    // Monitor: a write is pending whenever the hold is valid and the FIFO has room.
    always @(negedge clk) begin
        if (!reset && fifo_wrreq) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write: got %0h expected no write", fifo_wrdata);
            end else if (fifo_full) begin
                chk("held_word_stable", fifo_wrdata, exp_q[0]);
            end else begin
                chk("fifo_wrdata", fifo_wrdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", dct_count, 0);
        chk("rst_buffer", dct_buffer, 0);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_wrdata", fifo_wrdata, 0);
        chk("rst_dropped", dropped_count, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;

        // Full word of codes 0,1,2,3,...
        for (int i = 0; i < 15; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // Partial word via flush, then flush on an empty buffer.
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("flush_word", fifo_wrdata, {2'b00, 4'd3, 6'b100111, 24'd0});
        idle(1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        idle(1'b0);

        // Blocked FIFO: one word held, one buffered, the rest dropped.
        for (int i = 0; i < 32; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b1);
        chk("drops_while_full", dropped_count, 2);
        chk("overflow_set", overflow, 1);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Sixteen back-to-back codes: the 16th lands in the emit cycle.
        for (int i = 0; i < 16; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
        chk("count_after_16", dct_count, 1);
        chk("drops_after_16", dropped_count, 2);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Trace disabled: valid pulses are ignored.
        for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 2'($urandom_range(0, 3)), ($urandom % 8) == 0,
                 ($urandom % 3) == 0, ($urandom % 8) != 0);

        // Drain, then set up a held word plus a 7-code partial buffer.
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        for (int i = 0; i < 22; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b1);
        chk("pre_reset_count", dct_count, 7);
        chk("pre_reset_wrreq", fifo_wrreq, 1);

        // Asynchronous reset mid-cycle.
        #1 reset = 1'b1;
        #1;
        chk("arst_count", dct_count, 0);
        chk("arst_buffer", dct_buffer, 0);
        chk("arst_wrreq", fifo_wrreq, 0);
        chk("arst_wrdata", fifo_wrdata, 0);
        chk("arst_dropped", dropped_count, 0);
        chk("arst_overflow", overflow, 0);
        m_codes.delete();
        exp_q.delete();
        m_hold = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_drops = 0;
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) idle(1'b0);

        chk("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
